// File: rtl/x9_pkg.sv
// Shared types and constants for the 8-bit ALU sharing logic.
// The arbiter never decodes commands; the constants exist for requesters and benches.
package x9_pkg;

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_ADC  = 4'b0001;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [3:0] CMD_SBC  = 4'b0011;
    localparam logic [3:0] CMD_AND  = 4'b0100;
    localparam logic [3:0] CMD_OR   = 4'b0101;
    localparam logic [3:0] CMD_XOR  = 4'b0110;
    localparam logic [3:0] CMD_NOT  = 4'b0111;
    localparam logic [3:0] CMD_SHL  = 4'b1000;
    localparam logic [3:0] CMD_SHR  = 4'b1001;
    localparam logic [3:0] CMD_ROL  = 4'b1010;
    localparam logic [3:0] CMD_ROR  = 4'b1011;
    localparam logic [3:0] CMD_INC  = 4'b1100;
    localparam logic [3:0] CMD_DEC  = 4'b1101;
    localparam logic [3:0] CMD_PASS = 4'b1110;
    localparam logic [3:0] CMD_RXOR = 4'b1111;

    typedef struct packed {
        logic [3:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
        logic       lock;
    } alu_req_t;

    typedef struct packed {
        logic [7:0] rslt;
        logic       sc;
        logic       pari;
        logic       one;
    } alu_rsp_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: searches req & mask starting one past ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  mask,
    output logic [N-1:0]  gnt
);

    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(ptr) + k) % N;
            if (!w_found && req[w_idx[PW-1:0]] && mask[w_idx[PW-1:0]]) begin
                gnt[w_idx[PW-1:0]] = 1'b1;
                w_found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between NREQ requesters: round-robin grant, optional lock for
// carry-chained ops, registered issue stage and registered one-hot response.
module alu_arbiter
    import x9_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*4-1:0] req_cmd,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ-1:0]   req_lock,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_rslt,
    output logic              rsp_sc,
    output logic              rsp_pari,
    output logic              rsp_one,
    output logic [3:0]        alu_cmd,
    output logic [7:0]        alu_inA,
    output logic [7:0]        alu_inB,
    output logic              alu_sc_i,
    input  logic [7:0]        alu_rslt,
    input  logic              alu_sc_o,
    input  logic              alu_pari,
    input  logic              alu_one
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_e r_state, w_state_next;
    logic [IW-1:0] r_owner, w_owner_next;
    logic [IW-1:0] r_rr_ptr, w_rr_ptr_next;
    logic [CW-1:0] r_lock_cnt, w_lock_cnt_next;

    logic [NREQ-1:0] w_mask, w_gnt;
    logic            w_accept;
    logic [IW-1:0]   w_win_id;
    alu_req_t        w_win_req;

    alu_req_t      r_iss;
    logic          r_iss_vld, r_iss_chain;
    logic [IW-1:0] r_iss_id;
    alu_rsp_t      r_rsp;
    logic          r_rsp_vld;
    logic [IW-1:0] r_rsp_id;
    logic          r_carry;

    // While locked, only the owner's bit survives the mask, so others never see ready.
    assign w_mask = (r_state == ARB_LOCKED) ? (NREQ'(1) << r_owner) : '1;

    rr_arbiter #(.N(NREQ), .PW(IW)) u_rr (
        .req  (req_valid),
        .ptr  (r_rr_ptr),
        .mask (w_mask),
        .gnt  (w_gnt)
    );

    assign req_ready = w_gnt & {NREQ{reset_n}};
    assign w_accept  = |req_ready;

    always_comb begin
        w_win_id  = '0;
        w_win_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_win_id       = IW'(i);
                w_win_req.cmd  = req_cmd[i*4 +: 4];
                w_win_req.a    = req_a[i*8 +: 8];
                w_win_req.b    = req_b[i*8 +: 8];
                w_win_req.lock = req_lock[i];
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_rr_ptr_next   = r_rr_ptr;
        w_lock_cnt_next = r_lock_cnt;
        if (w_accept) begin
            case (r_state)
                ARB_IDLE: begin
                    w_rr_ptr_next = w_win_id;
                    if (w_win_req.lock && MAX_LOCK > 1) begin
                        w_state_next    = ARB_LOCKED;
                        w_owner_next    = w_win_id;
                        w_lock_cnt_next = CW'(1);
                    end
                end
                default: begin
                    // Releasing with rr_ptr at the owner hands the next turn to the others.
                    if (!w_win_req.lock || (int'(r_lock_cnt) + 1 >= MAX_LOCK)) begin
                        w_state_next    = ARB_IDLE;
                        w_rr_ptr_next   = r_owner;
                        w_lock_cnt_next = '0;
                    end else begin
                        w_lock_cnt_next = r_lock_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ARB_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= IW'(NREQ - 1);
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_lock_cnt <= w_lock_cnt_next;
        end
    end

    // r_iss keeps the last accepted op after it issues, so it also tells whether the
    // next accepted op continues a locked chain from the same requester.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_iss       <= '0;
            r_iss_vld   <= 1'b0;
            r_iss_chain <= 1'b0;
            r_iss_id    <= '0;
            r_rsp       <= '0;
            r_rsp_vld   <= 1'b0;
            r_rsp_id    <= '0;
            r_carry     <= 1'b0;
        end else begin
            r_iss_vld <= w_accept;
            if (w_accept) begin
                r_iss       <= w_win_req;
                r_iss_id    <= w_win_id;
                r_iss_chain <= r_iss.lock && (r_iss_id == w_win_id);
            end
            r_rsp_vld <= r_iss_vld;
            if (r_iss_vld) begin
                r_rsp    <= '{rslt: alu_rslt, sc: alu_sc_o, pari: alu_pari, one: alu_one};
                r_rsp_id <= r_iss_id;
                r_carry  <= alu_sc_o;
            end
        end
    end

    assign alu_cmd  = r_iss_vld ? r_iss.cmd : 4'd0;
    assign alu_inA  = r_iss_vld ? r_iss.a : 8'd0;
    assign alu_inB  = r_iss_vld ? r_iss.b : 8'd0;
    assign alu_sc_i = r_iss_vld & r_iss_chain & r_carry;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = r_rsp_vld && (r_rsp_id == IW'(i));
        end
    end

    assign rsp_rslt = r_rsp.rslt;
    assign rsp_sc   = r_rsp.sc;
    assign rsp_pari = r_rsp.pari;
    assign rsp_one  = r_rsp.one;

endmodule
